// File: rtl/xi_proj_cal.sv
// Real projections xI_k = Re(sum_t coef_k,t * y_t) >>> DIV_SHIFT over one latched channel block.
// Streams one rounded, saturated result per symbol, then pulses done.
module xi_proj_cal #(
  parameter int W         = 16,
  parameter int FRAC      = 8,
  parameter int N_ELEM    = 4,
  parameter int N_COL     = 2,
  parameter int N_SYM     = 4,
  parameter int DIV_SHIFT = 1,
  localparam int N_TERMS  = N_COL * N_ELEM,
  localparam int KW       = (N_SYM > 1) ? $clog2(N_SYM) : 1
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         start,
  input  logic                         abort,
  input  logic [N_TERMS*W-1:0]         col_r,
  input  logic [N_TERMS*W-1:0]         col_i,
  input  logic [3*N_TERMS*N_SYM-1:0]   coef,
  output logic                         busy,
  output logic [W-1:0]                 xi_out,
  output logic                         xi_valid,
  output logic [KW-1:0]                xi_idx,
  output logic                         done
);

  localparam int TW = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
  localparam int AW = W + $clog2(N_TERMS) + 1;
  localparam logic [TW-1:0] T_LAST = TW'(N_TERMS - 1);
  localparam logic [KW-1:0] K_LAST = KW'(N_SYM - 1);
  localparam logic signed [AW:0] RND    = (AW+1)'((1 << DIV_SHIFT) >> 1);
  localparam logic signed [AW:0] SAT_HI = (AW+1)'((2 ** (W-1)) - 1);
  localparam logic signed [AW:0] SAT_LO = (AW+1)'(-(2 ** (W-1)));

  if (FRAC > W) begin : g_frac_range
    $error("FRAC must not exceed W");
  end

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_OUT, S_DONE} state_t;

  state_t state_q, state_d;

  logic [N_TERMS*W-1:0]       col_r_q, col_i_q;
  logic [3*N_TERMS*N_SYM-1:0] coef_q;
  logic signed [AW-1:0]       acc_q, acc_d;
  logic [TW-1:0]              t_q, t_d;
  logic [KW-1:0]              k_q, k_d;
  logic [W-1:0]               xi_out_q, xi_out_d;
  logic [KW-1:0]              xi_idx_q, xi_idx_d;
  logic                       xi_valid_q, xi_valid_d;
  logic                       done_q, done_d;
  logic                       load;

  logic signed [W-1:0]  y_r, y_i;
  logic [2:0]           code;
  logic signed [AW-1:0] yr_ext, yi_ext, contrib;
  logic signed [AW:0]   acc_sum, acc_sh;
  logic [W-1:0]         xi_sat;

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; abort overrides every transition
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (start) state_d = S_ACC;
        S_ACC:   if (t_q == T_LAST) state_d = S_OUT;
        S_OUT:   state_d = (k_q == K_LAST) ? S_DONE : S_ACC;
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output logic
  always_comb begin
    busy     = (state_q != S_IDLE);
    xi_out   = xi_out_q;
    xi_idx   = xi_idx_q;
    xi_valid = xi_valid_q;
    done     = done_q;
  end

  // Term selection and signed contribution
  always_comb begin
    y_r    = col_r_q[int'(t_q)*W +: W];
    y_i    = col_i_q[int'(t_q)*W +: W];
    code   = coef_q[(int'(k_q)*N_TERMS + int'(t_q))*3 +: 3];
    yr_ext = {{(AW-W){y_r[W-1]}}, y_r};
    yi_ext = {{(AW-W){y_i[W-1]}}, y_i};
    case (code)
      3'b001:  contrib = yr_ext;
      3'b010:  contrib = -yr_ext;
      3'b011:  contrib = -yi_ext;
      3'b100:  contrib = yi_ext;
      default: contrib = '0;
    endcase
  end

  // Round half toward +inf, then clamp to the W-bit rails
  always_comb begin
    acc_sum = $signed({acc_q[AW-1], acc_q}) + RND;
    acc_sh  = acc_sum >>> DIV_SHIFT;
    if (acc_sh > SAT_HI)      xi_sat = SAT_HI[W-1:0];
    else if (acc_sh < SAT_LO) xi_sat = SAT_LO[W-1:0];
    else                      xi_sat = acc_sh[W-1:0];
  end

  always_comb begin
    acc_d      = acc_q;
    t_d        = t_q;
    k_d        = k_q;
    xi_out_d   = xi_out_q;
    xi_idx_d   = xi_idx_q;
    xi_valid_d = 1'b0;
    done_d     = 1'b0;
    load       = 1'b0;
    if (abort) begin
      acc_d = '0;
      t_d   = '0;
      k_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            load  = 1'b1;
            acc_d = '0;
            t_d   = '0;
            k_d   = '0;
          end
        end
        S_ACC: begin
          acc_d = acc_q + contrib;
          t_d   = (t_q == T_LAST) ? '0 : t_q + 1'b1;
        end
        S_OUT: begin
          xi_out_d   = xi_sat;
          xi_idx_d   = k_q;
          xi_valid_d = 1'b1;
          acc_d      = '0;
          t_d        = '0;
          if (k_q != K_LAST) k_d = k_q + 1'b1;
        end
        S_DONE:  done_d = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      col_r_q    <= '0;
      col_i_q    <= '0;
      coef_q     <= '0;
      acc_q      <= '0;
      t_q        <= '0;
      k_q        <= '0;
      xi_out_q   <= '0;
      xi_idx_q   <= '0;
      xi_valid_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      if (load) begin
        col_r_q <= col_r;
        col_i_q <= col_i;
        coef_q  <= coef;
      end
      acc_q      <= acc_d;
      t_q        <= t_d;
      k_q        <= k_d;
      xi_out_q   <= xi_out_d;
      xi_idx_q   <= xi_idx_d;
      xi_valid_q <= xi_valid_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_xi_proj_cal.sv
// Directed bench for xi_proj_cal: default instance plus an 8-symbol, unscaled instance.
module tb_xi_proj_cal;
  localparam int W   = 16;
  localparam int NT  = 8;
  localparam int NSA = 4;
  localparam int NSB = 8;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic                   start_a = 1'b0, abort_a = 1'b0;
  logic [NT*W-1:0]        col_r_a = '0, col_i_a = '0;
  logic [3*NT*NSA-1:0]    coef_a = '0;
  logic                   busy_a, xi_valid_a, done_a;
  logic [W-1:0]           xi_out_a;
  logic [1:0]             xi_idx_a;

  logic                   start_b = 1'b0, abort_b = 1'b0;
  logic [NT*W-1:0]        col_r_b = '0, col_i_b = '0;
  logic [3*NT*NSB-1:0]    coef_b = '0;
  logic                   busy_b, xi_valid_b, done_b;
  logic [W-1:0]           xi_out_b;
  logic [2:0]             xi_idx_b;

  xi_proj_cal dut_a (
    .clk(clk), .rstn(rstn), .start(start_a), .abort(abort_a),
    .col_r(col_r_a), .col_i(col_i_a), .coef(coef_a),
    .busy(busy_a), .xi_out(xi_out_a), .xi_valid(xi_valid_a),
    .xi_idx(xi_idx_a), .done(done_a)
  );

  xi_proj_cal #(.N_ELEM(2), .N_COL(4), .N_SYM(8), .DIV_SHIFT(0)) dut_b (
    .clk(clk), .rstn(rstn), .start(start_b), .abort(abort_b),
    .col_r(col_r_b), .col_i(col_i_b), .coef(coef_b),
    .busy(busy_b), .xi_out(xi_out_b), .xi_valid(xi_valid_b),
    .xi_idx(xi_idx_b), .done(done_b)
  );

  int checks = 0;
  int failures = 0;

  logic [NT*W-1:0]     v_r, v_i;
  logic [3*NT*NSB-1:0] v_c;

  int          nv;
  int          done_cyc;
  int          rc [0:15];
  int          ri [0:15];
  logic [15:0] rv [0:15];
  logic        busyv [0:80];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    v_r = '0; v_i = '0; v_c = '0;
  endtask

  task automatic setr(input int t, input logic [15:0] x);
    v_r[t*W +: W] = x;
  endtask

  task automatic seti(input int t, input logic [15:0] x);
    v_i[t*W +: W] = x;
  endtask

  task automatic setc(input int k, input int t, input logic [2:0] c);
    v_c[(k*NT+t)*3 +: 3] = c;
  endtask

  // Called at posedge+1; start is sampled on the next edge (cycle 0).
  task automatic run_a(input int abort_at, input int restart_at);
    nv = 0; done_cyc = -1;
    col_r_a = v_r; col_i_a = v_i; coef_a = v_c[3*NT*NSA-1:0];
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    for (int c = 1; c <= 45; c++) begin
      if (c == 2) begin
        col_r_a = ~col_r_a; col_i_a = ~col_i_a; coef_a = ~coef_a;
      end
      abort_a = (c == abort_at);
      start_a = (c == restart_at);
      @(posedge clk); #1;
      busyv[c] = busy_a;
      if (xi_valid_a && nv < 16) begin
        rc[nv] = c; ri[nv] = int'(xi_idx_a); rv[nv] = xi_out_a; nv++;
      end
      if (done_a) done_cyc = c;
    end
    abort_a = 1'b0; start_a = 1'b0;
  endtask

  task automatic run_b();
    nv = 0; done_cyc = -1;
    col_r_b = v_r; col_i_b = v_i; coef_b = v_c;
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    for (int c = 1; c <= 80; c++) begin
      if (c == 2) begin
        col_r_b = ~col_r_b; col_i_b = ~col_i_b; coef_b = ~coef_b;
      end
      @(posedge clk); #1;
      if (xi_valid_b && nv < 16) begin
        rc[nv] = c; ri[nv] = int'(xi_idx_b); rv[nv] = xi_out_b; nv++;
      end
      if (done_b) done_cyc = c;
    end
  endtask

  task automatic chk_block(input string name, input logic [15:0] e0, input logic [15:0] e1,
                           input logic [15:0] e2, input logic [15:0] e3);
    logic [15:0] e [0:3];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    chk($sformatf("%s.count", name), nv, 4);
    for (int k = 0; k < 4 && k < nv; k++) begin
      chk($sformatf("%s.cyc%0d", name, k), rc[k], 9*(k+1));
      chk($sformatf("%s.idx%0d", name, k), ri[k], k);
      chk($sformatf("%s.val%0d", name, k), 32'(rv[k]), 32'(e[k]));
    end
    chk($sformatf("%s.done", name), done_cyc, 37);
  endtask

  initial begin
    logic [15:0] eb [0:7];

    #2;
    chk("rst.busy", 32'(busy_a), 0);
    chk("rst.valid", 32'(xi_valid_a), 0);
    chk("rst.out", 32'(xi_out_a), 0);
    chk("rst.idx", 32'(xi_idx_a), 0);
    chk("rst.done", 32'(done_a), 0);
    @(negedge clk); rstn = 1'b1;
    @(posedge clk); #1;

    // single real term, halved
    clr(); setr(0, 16'h0100); setc(0, 0, 3'b001);
    run_a(0, 0);
    chk_block("t1", 16'h0080, 16'h0000, 16'h0000, 16'h0000);

    // imaginary term with -j then +j
    clr(); seti(5, 16'h0300); setc(2, 5, 3'b100);
    run_a(0, 0);
    chk_block("t2a", 16'h0000, 16'h0000, 16'h0180, 16'h0000);
    clr(); seti(5, 16'h0300); setc(2, 5, 3'b011);
    run_a(0, 0);
    chk_block("t2b", 16'h0000, 16'h0000, 16'hFE80, 16'h0000);

    // saturation on both rails
    clr();
    for (int t = 0; t < NT; t++) begin
      setr(t, 16'h7FFF); setc(0, t, 3'b001); setc(1, t, 3'b010);
    end
    run_a(0, 0);
    chk_block("t3", 16'h7FFF, 16'h8000, 16'h0000, 16'h0000);

    // rounding: +3 -> 2, -3 -> -1, -1 -> 0, +1 -> 1 (code 111 contributes nothing)
    clr(); setr(0, 16'h0003); setr(1, 16'h0001);
    setc(0, 0, 3'b001); setc(1, 0, 3'b010); setc(2, 1, 3'b010);
    setc(3, 1, 3'b001); setc(3, 0, 3'b111);
    run_a(0, 0);
    chk_block("t4", 16'h0002, 16'hFFFF, 16'h0000, 16'h0001);

    // start during ACC ignored; start in DONE cycle ignored
    clr(); setr(0, 16'h0100); setc(0, 0, 3'b001);
    run_a(0, 3);
    chk_block("t5a", 16'h0080, 16'h0000, 16'h0000, 16'h0000);
    clr(); setr(0, 16'h0100); setc(0, 0, 3'b001);
    run_a(0, 37);
    chk("t5_done_start.busy", 32'(busyv[37]), 0);

    // abort in ACC of k=1
    run_a(12, 0);
    chk("ab12.count", nv, 1);
    chk("ab12.val0", 32'(rv[0]), 32'h0080);
    chk("ab12.done", done_cyc, -1);
    chk("ab12.busy_before", 32'(busyv[11]), 1);
    chk("ab12.busy_after", 32'(busyv[12]), 0);
    // abort on the OUT cycle of k=1 suppresses that strobe
    run_a(18, 0);
    chk("ab18.count", nv, 1);
    chk("ab18.done", done_cyc, -1);
    run_a(0, 0);
    chk_block("t5b", 16'h0080, 16'h0000, 16'h0000, 16'h0000);

    // start and abort together in IDLE: not started
    abort_a = 1'b1; start_a = 1'b1;
    @(posedge clk); #1;
    abort_a = 1'b0; start_a = 1'b0;
    chk("ab_idle.busy", 32'(busy_a), 0);
    @(posedge clk); #1;
    chk("ab_idle.busy2", 32'(busy_a), 0);

    // async reset mid-ACC of k=1
    col_r_a = v_r; col_i_a = v_i; coef_a = v_c[3*NT*NSA-1:0];
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (11) @(posedge clk);
    #3;
    chk("rst6.pre_out", 32'(xi_out_a), 32'h0080);
    chk("rst6.pre_busy", 32'(busy_a), 1);
    rstn = 1'b0;
    #1;
    chk("rst6.busy", 32'(busy_a), 0);
    chk("rst6.out", 32'(xi_out_a), 0);
    chk("rst6.valid", 32'(xi_valid_a), 0);
    chk("rst6.idx", 32'(xi_idx_a), 0);
    chk("rst6.done", 32'(done_a), 0);
    @(negedge clk); rstn = 1'b1;
    @(posedge clk); #1;
    chk("rst6.idle", 32'(busy_a), 0);
    run_a(0, 0);
    chk_block("t6", 16'h0080, 16'h0000, 16'h0000, 16'h0000);

    // second parameter set: 8 symbols, no scaling
    clr();
    setr(3, 16'h0100); seti(6, 16'h0040); setr(0, 16'h0003);
    setc(0, 3, 3'b001);
    setc(1, 0, 3'b001);
    setc(2, 3, 3'b010);
    setc(5, 6, 3'b011);
    setc(6, 0, 3'b010);
    setc(7, 3, 3'b010); setc(7, 6, 3'b100);
    eb[0] = 16'h0100; eb[1] = 16'h0003; eb[2] = 16'hFF00; eb[3] = 16'h0000;
    eb[4] = 16'h0000; eb[5] = 16'hFFC0; eb[6] = 16'hFFFD; eb[7] = 16'hFF40;
    run_b();
    chk("b.count", nv, 8);
    for (int k = 0; k < 8 && k < nv; k++) begin
      chk($sformatf("b.cyc%0d", k), rc[k], 9*(k+1));
      chk($sformatf("b.idx%0d", k), ri[k], k);
      chk($sformatf("b.val%0d", k), 32'(rv[k]), 32'(eb[k]));
    end
    chk("b.done", done_cyc, 73);
    chk("b.busy_end", 32'(busy_b), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
